mc_controller: RTL and testbench

Parametrised multicycle controller for the 8-opcode accumulator RISC CPU, and the successor of the fixed 8-state controller. It adds a memory ready handshake with bounded wait states and a timeout fault. It also adds a configurable skip distance and an explicit HALTED state. It sits between the IR opcode field, the ALU zero flag, the memory interface, and the PC/AC/IR load enables.

---
 rtl/mc_controller_pkg.sv | 31 +++
 rtl/mc_wait_timer.sv | 33 +++
 rtl/mc_controller.sv | 164 ++++++++++++++++
 tb/tb_mc_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared opcode and state encodings for the multicycle accumulator-CPU controller.
package mc_controller_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [STATE_W-1:0] S_INST_ADDR  = 4'd0;
  localparam logic [STATE_W-1:0] S_INST_FETCH = 4'd1;
  localparam logic [STATE_W-1:0] S_INST_LOAD  = 4'd2;
  localparam logic [STATE_W-1:0] S_OP_ADDR    = 4'd3;
  localparam logic [STATE_W-1:0] S_OP_FETCH   = 4'd4;
  localparam logic [STATE_W-1:0] S_ALU_OP     = 4'd5;
  localparam logic [STATE_W-1:0] S_STORE      = 4'd6;
  localparam logic [STATE_W-1:0] S_NEXT       = 4'd7;
  localparam logic [STATE_W-1:0] S_HALTED     = 4'd8;
  localparam logic [STATE_W-1:0] S_FAULT      = 4'd9;

  // Opcodes that read an operand from memory and load the accumulator
  function automatic logic is_ac_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; flags a timeout when a stalled access reaches MEM_TIMEOUT cycles.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout_c
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stalled_c;

  assign stalled_c = waiting && !mem_ready;
  // A ready arriving on the last allowed cycle clears stalled_c, so it beats the timeout
  assign timeout_c = (MEM_TIMEOUT != 0) && stalled_c && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!stalled_c || timeout_c) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller with memory handshake, wait timeout fault, skip distance and halt state.
// Optional single-step debug input enabled by macro CTRL_STEP_EN.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned OPC_W       = 3,
  parameter int unsigned PC_INC_W    = 2,
  parameter int unsigned SKIP_DIST   = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                zero,
  input  logic                mem_ready,
`ifdef CTRL_STEP_EN
  input  logic                step,
`endif
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e,
  output logic [PC_INC_W-1:0] inc_pc,
  output logic                halt,
  output logic                mem_err,
  output logic [STATE_W-1:0]  state
);

  logic [STATE_W-1:0] state_q, state_nxt;
  logic               skip_next_q;
  logic               mem_err_q;
  logic               op_ok, step_ok, waiting, timeout_c;
  logic [2:0]         op;
  logic               is_hlt, is_skz, is_ac, is_sto, is_jmp;

`ifdef CTRL_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // Nonzero upper opcode bits decode as a NOP
  generate
    if (OPC_W > 3) begin : g_wide_op
      assign op_ok = (opcode[OPC_W-1:3] == '0);
    end else begin : g_narrow_op
      assign op_ok = 1'b1;
    end
  endgenerate

  assign op     = opcode[2:0];
  assign is_hlt = op_ok && (op == OP_HLT);
  assign is_skz = op_ok && (op == OP_SKZ);
  assign is_ac  = op_ok && is_ac_op(op);
  assign is_sto = op_ok && (op == OP_STO);
  assign is_jmp = op_ok && (op == OP_JMP);

  assign waiting = (state_q == S_INST_FETCH) ||
                   ((state_q == S_OP_FETCH) && is_ac) ||
                   ((state_q == S_STORE) && is_sto);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .timeout_c (timeout_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INST_ADDR;
      skip_next_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_ALU_OP) begin
        skip_next_q <= is_skz && zero;
      end else if ((state_q == S_NEXT) && step_ok) begin
        skip_next_q <= 1'b0;
      end
      if (state_nxt == S_FAULT) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  // Next-state logic; waiting states advance on mem_ready or fault on timeout
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_INST_ADDR:  state_nxt = S_INST_FETCH;
      S_INST_FETCH: begin
        if (mem_ready)      state_nxt = S_INST_LOAD;
        else if (timeout_c) state_nxt = S_FAULT;
      end
      S_INST_LOAD:  state_nxt = S_OP_ADDR;
      S_OP_ADDR:    state_nxt = S_OP_FETCH;
      S_OP_FETCH: begin
        if (!is_ac || mem_ready) state_nxt = S_ALU_OP;
        else if (timeout_c)      state_nxt = S_FAULT;
      end
      S_ALU_OP:     state_nxt = is_hlt ? S_NEXT : S_STORE;
      S_STORE: begin
        if (!is_sto || mem_ready) state_nxt = S_NEXT;
        else if (timeout_c)       state_nxt = S_FAULT;
      end
      S_NEXT: begin
        if (step_ok) state_nxt = is_hlt ? S_HALTED : S_INST_ADDR;
      end
      S_HALTED:     state_nxt = S_HALTED;
      S_FAULT:      state_nxt = S_FAULT;
      default:      state_nxt = S_FAULT;
    endcase
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    inc_pc = '0;
    halt   = 1'b0;
    case (state_q)
      S_INST_ADDR:  sel = 1'b1;
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_OP_FETCH:   rd    = is_ac;
      S_ALU_OP:     ld_pc = is_jmp;
      S_STORE: begin
        ld_ac  = is_ac;
        wr     = is_sto;
        data_e = is_sto;
      end
      S_NEXT: begin
        if (step_ok) begin
          if (skip_next_q)            inc_pc = PC_INC_W'(SKIP_DIST);
          else if (is_hlt || is_jmp)  inc_pc = '0;
          else                        inc_pc = PC_INC_W'(1);
        end
      end
      S_HALTED:     halt = 1'b1;
      S_FAULT:      halt = 1'b1;
      default:      halt = 1'b0;
    endcase
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle plans from a phase-level model.
module tb_mc_controller;

  localparam int unsigned OPC_W       = 4;
  localparam int unsigned PC_INC_W    = 2;
  localparam int unsigned SKIP_DIST   = 2;
  localparam int unsigned MEM_TIMEOUT = 4;

  logic                clk = 1'b0;
  logic                rst, zero, mem_ready, step;
  logic [OPC_W-1:0]    opcode;
  logic                sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e, halt, mem_err;
  logic [PC_INC_W-1:0] inc_pc;
  logic [3:0]          state;

  typedef struct packed {
    logic       sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e;
    logic [1:0] inc_pc;
    logic       halt, mem_err;
    logic [3:0] state;
  } exp_t;

  typedef struct {
    logic       rst, mr, z;
    logic [3:0] opc;
    exp_t       e;
  } cyc_t;

  cyc_t plan[$];
  exp_t sb[$];
  exp_t act, mon_e;
  int   n_tests = 0, n_fail = 0, mark = 0, n_cyc = 0;

  mc_controller #(
    .OPC_W(OPC_W), .PC_INC_W(PC_INC_W), .SKIP_DIST(SKIP_DIST), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
`ifdef CTRL_STEP_EN
    .step(step),
`endif
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr),
    .data_e(data_e), .inc_pc(inc_pc), .halt(halt), .mem_err(mem_err), .state(state)
  );

  assign act = {sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e, inc_pc, halt, mem_err, state};

  initial forever #5 clk = ~clk;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic void add(input exp_t e, input logic mr, input logic [3:0] opc, input logic z);
    cyc_t c;
    c.rst = 1'b0; c.mr = mr; c.z = z; c.opc = opc; c.e = e;
    plan.push_back(c);
  endfunction

  function automatic void add_reset();
    cyc_t c;
    c.rst = 1'b1; c.mr = rnd(); c.z = rnd(); c.opc = 4'($urandom);
    c.e = mk(4'd0);
    c.e.sel = 1'b1;
    plan.push_back(c);
  endfunction

  function automatic void add_fault(input logic [3:0] opc);
    exp_t e;
    e = mk(4'd9);
    e.halt = 1'b1;
    e.mem_err = 1'b1;
    for (int i = 0; i < 6; i++) add(e, rnd(), opc, rnd());
  endfunction

  // A memory phase with w not-ready cycles before ready; returns 0 if it times out
  function automatic bit wait_phase(input exp_t e, input int w, input logic [3:0] opc);
    int n;
    n = (w < int'(MEM_TIMEOUT)) ? w : int'(MEM_TIMEOUT);
    for (int i = 0; i < n; i++) add(e, 1'b0, opc, rnd());
    if (w >= int'(MEM_TIMEOUT)) begin
      add_fault(opc);
      return 1'b0;
    end
    add(e, 1'b1, opc, rnd());
    return 1'b1;
  endfunction

  // Expected per-cycle behaviour of one instruction from the controller's phase rules
  function automatic void build(input logic [3:0] opc, input logic z, input int wif,
                                input int wof, input int wst, input int nhalt);
    logic [2:0] op;
    bit   ok, hlt, skz, ac, sto, jmp;
    exp_t e;
    op  = opc[2:0];
    ok  = (opc[3] == 1'b0);
    hlt = ok && (op == 3'd0);
    skz = ok && (op == 3'd1);
    ac  = ok && (op >= 3'd2) && (op <= 3'd5);
    sto = ok && (op == 3'd6);
    jmp = ok && (op == 3'd7);
    e = mk(4'd0); e.sel = 1'b1;
    add(e, rnd(), opc, rnd());
    e = mk(4'd1); e.sel = 1'b1; e.rd = 1'b1;
    if (!wait_phase(e, wif, opc)) return;
    e = mk(4'd2); e.sel = 1'b1; e.rd = 1'b1; e.ld_ir = 1'b1;
    add(e, rnd(), opc, rnd());
    e = mk(4'd3);
    add(e, rnd(), opc, rnd());
    e = mk(4'd4);
    if (ac) begin
      e.rd = 1'b1;
      if (!wait_phase(e, wof, opc)) return;
    end else begin
      add(e, rnd(), opc, rnd());
    end
    e = mk(4'd5); e.ld_pc = jmp;
    add(e, rnd(), opc, z);
    if (!hlt) begin
      e = mk(4'd6);
      mark = plan.size();
      if (sto) begin
        e.wr = 1'b1; e.data_e = 1'b1;
        if (!wait_phase(e, wst, opc)) return;
      end else begin
        e.ld_ac = ac;
        add(e, rnd(), opc, rnd());
      end
    end
    e = mk(4'd7);
    e.inc_pc = (skz && z) ? 2'(SKIP_DIST) : ((hlt || jmp) ? 2'd0 : 2'd1);
    add(e, rnd(), opc, rnd());
    if (hlt) begin
      e = mk(4'd8); e.halt = 1'b1;
      for (int i = 0; i < nhalt; i++) add(e, rnd(), opc, rnd());
    end
  endfunction

  function automatic void truncate(input int n);
    while (plan.size() > n) void'(plan.pop_back());
  endfunction

  task automatic flush();
    cyc_t c;
    while (plan.size() != 0) begin
      c = plan.pop_front();
      @(negedge clk);
      rst = c.rst; mem_ready = c.mr; zero = c.z; opcode = c.opc;
      sb.push_back(c.e);
    end
  endtask

  // Monitor: every cycle with a pending expectation is checked mid-cycle
  initial forever begin
    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL cycle%0d state got=%0d exp=%0d outputs got=%h exp=%h",
                 n_cyc, act.state, mon_e.state, act, mon_e);
      end
      n_cyc++;
    end
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; step = 1'b1;
    add_reset(); add_reset(); flush();
    build(4'd2, 1'b0, 0, 0, 0, 0); flush();                  // ADD, ready always
    build(4'd1, 1'b1, 0, 0, 0, 0); build(4'd1, 1'b0, 0, 0, 0, 0); flush();
    build(4'd5, 1'b0, 3, 0, 0, 0); build(4'd5, 1'b1, 0, 3, 0, 0); flush();
    for (int i = 0; i < 40; i++) begin
      build(4'($urandom_range(1, 15)), rnd(), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      flush();
    end
    build(4'd6, 1'b0, 0, 0, 2, 0); build(4'd0, 1'b0, 1, 0, 0, 22); add_reset(); flush();
    build(4'd2, 1'b0, 4, 0, 0, 0); add_reset(); flush();     // timeout in fetch
    build(4'd3, 1'b0, 0, 6, 0, 0); add_reset(); flush();     // timeout in operand fetch
    build(4'd6, 1'b0, 0, 0, 4, 0); add_reset(); flush();     // timeout in store
    build(4'd1, 1'b1, 0, 0, 0, 0); truncate(mark + 1); add_reset();
    build(4'd2, 1'b0, 0, 0, 0, 0); flush();                  // skip must not survive reset
    build(4'd6, 1'b0, 1, 1, 3, 0); truncate(mark + 2); add_reset();
    build(4'd7, 1'b0, 0, 0, 0, 0); flush();                  // reset mid store wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
